// File: rtl/axi_mem_loader.sv
// AXI4-Lite write-only slave that turns host word writes into single-cycle program-memory write strobes.
// Optional AXI_MEM_LOADER_WCOUNT_EN adds a saturating count of OKAY memory writes on port wcount.
module axi_mem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          MEM_AW    = 9,
    parameter int          DATA_W    = 32
) (
    input  logic              clk,
`ifdef AXI_MEM_LOADER_WCOUNT_EN
    output logic [MEM_AW:0]   wcount,
`endif
    input  logic              reset,
    input  logic [31:0]       s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [DATA_W-1:0] s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic              axi_mem_w,
    output logic [MEM_AW-1:0] axi_mem_addr,
    output logic [DATA_W-1:0] axi_mem_data
);

    typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;

    state_t              r_state, w_next;
    logic                r_aw_held, r_w_held;
    logic [31:0]         r_awaddr;
    logic [DATA_W-1:0]   r_wdata;
    logic [3:0]          r_wstrb;
    logic                r_awready, r_wready, r_bvalid, r_ok, r_mem_w;
    logic [1:0]          r_bresp;
    logic [MEM_AW-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_data;

    logic                w_aw_hs, w_w_hs, w_capture, w_ok;
    logic [31:0]         w_addr, w_off;
    logic [DATA_W-1:0]   w_data;
    logic [3:0]          w_strb;

    assign w_aw_hs   = s_awvalid & r_awready;
    assign w_w_hs    = s_wvalid & r_wready;
    // Bypass the capture regs so a same-edge handshake can launch the write immediately.
    assign w_addr    = r_aw_held ? r_awaddr : s_awaddr;
    assign w_data    = r_w_held  ? r_wdata  : s_wdata;
    assign w_strb    = r_w_held  ? r_wstrb  : s_wstrb;
    assign w_off     = w_addr - BASE_ADDR;
    assign w_ok      = (w_off[1:0] == 2'b00) && ((w_off >> (MEM_AW + 2)) == 32'd0) && (w_strb == 4'hF);
    assign w_capture = (r_state == IDLE) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_capture) w_next = WRITE;
            WRITE:   w_next = RESP;
            RESP:    if (r_bvalid && s_bready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= 2'b00;
            r_ok       <= 1'b0;
            r_mem_w    <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            r_mem_w <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_awready <= !(r_aw_held || w_aw_hs);
                    r_wready  <= !(r_w_held || w_w_hs);
                    if (w_aw_hs) begin
                        r_aw_held <= 1'b1;
                        r_awaddr  <= s_awaddr;
                    end
                    if (w_w_hs) begin
                        r_w_held <= 1'b1;
                        r_wdata  <= s_wdata;
                        r_wstrb  <= s_wstrb;
                    end
                    if (w_capture) begin
                        r_ok    <= w_ok;
                        r_mem_w <= w_ok;
                        if (w_ok) begin
                            r_mem_addr <= w_off[MEM_AW+1:2];
                            r_mem_data <= w_data;
                        end
                    end
                end
                WRITE: begin
                    r_bvalid <= 1'b1;
                    r_bresp  <= r_ok ? 2'b00 : 2'b10;
                end
                RESP: begin
                    if (s_bready) begin
                        r_bvalid  <= 1'b0;
                        r_bresp   <= 2'b00;
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef AXI_MEM_LOADER_WCOUNT_EN
    localparam logic [MEM_AW:0] WC_ONE = 1;
    logic [MEM_AW:0] r_wcount;

    always_ff @(posedge clk) begin
        if (reset)
            r_wcount <= '0;
        else if (r_state == WRITE && r_ok && r_wcount != '1)
            r_wcount <= r_wcount + WC_ONE;
    end

    assign wcount = r_wcount;
`endif

    assign s_awready    = r_awready;
    assign s_wready     = r_wready;
    assign s_bvalid     = r_bvalid;
    assign s_bresp      = r_bresp;
    assign axi_mem_w    = r_mem_w;
    assign axi_mem_addr = r_mem_addr;
    assign axi_mem_data = r_mem_data;

endmodule

// File: tb/tb_axi_mem_loader.sv
// Directed self-checking bench for axi_mem_loader: handshake ordering, error decoding,
// B backpressure, mid-transaction reset and (when enabled) the OKAY write counter.
module tb_axi_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic        axi_mem_w;
    logic [8:0]  axi_mem_addr;
    logic [31:0] axi_mem_data;
`ifdef AXI_MEM_LOADER_WCOUNT_EN
    logic [9:0]  wcount;
`endif

    int n_chk = 0;
    int n_err = 0;
    int wpulse = 0;
    logic prev_w = 1'b0;

    always #5 clk = ~clk;

    axi_mem_loader dut (
        .clk          (clk),
`ifdef AXI_MEM_LOADER_WCOUNT_EN
        .wcount       (wcount),
`endif
        .reset        (reset),
        .s_awaddr     (s_awaddr),
        .s_awvalid    (s_awvalid),
        .s_awready    (s_awready),
        .s_wdata      (s_wdata),
        .s_wstrb      (s_wstrb),
        .s_wvalid     (s_wvalid),
        .s_wready     (s_wready),
        .s_bresp      (s_bresp),
        .s_bvalid     (s_bvalid),
        .s_bready     (s_bready),
        .axi_mem_w    (axi_mem_w),
        .axi_mem_addr (axi_mem_addr),
        .axi_mem_data (axi_mem_data)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Strobe monitor, sampled 2ns after each edge so it never races the stimulus thread.
    always @(posedge clk) begin
        #2;
        if (axi_mem_w === 1'b1) begin
            chk("mem_w_consecutive", {31'd0, prev_w}, 32'd0);
            wpulse++;
        end
        prev_w = (axi_mem_w === 1'b1);
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full AXI write. W is presented first; AW follows w_lead cycles later (0 = same cycle).
    // bp = number of extra cycles bready is held low once bvalid is up.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int w_lead, input int bp, input logic exp_ok,
                             input logic [8:0] exp_maddr);
        int   cyc;
        int   p0;
        logic aw_done, w_done, aw_fire, w_fire;
        p0       = wpulse;
        aw_done  = 1'b0;
        w_done   = 1'b0;
        cyc      = 0;
        s_bready = (bp == 0);
        s_wdata  = data;
        s_wstrb  = strb;
        s_wvalid = 1'b1;
        s_awaddr = addr;
        while (!(aw_done && w_done) && cyc < 50) begin
            if (cyc == w_lead && !aw_done) s_awvalid = 1'b1;
            aw_fire = s_awvalid && s_awready;
            w_fire  = s_wvalid && s_wready;
            tick();
            if (aw_fire) begin aw_done = 1'b1; s_awvalid = 1'b0; end
            if (w_fire)  begin w_done  = 1'b1; s_wvalid  = 1'b0; end
            if (w_done && !aw_done) chk("wready_while_waiting", {31'd0, s_wready}, 32'd0);
            cyc++;
        end
        if (cyc >= 50) chk("handshake_timeout", 32'd1, 32'd0);
        chk("mem_w", {31'd0, axi_mem_w}, {31'd0, exp_ok});
        if (exp_ok) begin
            chk("mem_addr", {23'd0, axi_mem_addr}, {23'd0, exp_maddr});
            chk("mem_data", axi_mem_data, data);
        end
        tick();
        chk("bvalid", {31'd0, s_bvalid}, 32'd1);
        chk("bresp", {30'd0, s_bresp}, exp_ok ? 32'd0 : 32'd2);
        chk("mem_w_after", {31'd0, axi_mem_w}, 32'd0);
        for (int i = 0; i < bp; i++) begin
            tick();
            chk("bp_bvalid", {31'd0, s_bvalid}, 32'd1);
            chk("bp_bresp", {30'd0, s_bresp}, exp_ok ? 32'd0 : 32'd2);
            chk("bp_readys", {30'd0, s_awready, s_wready}, 32'd0);
        end
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        chk("bvalid_drop", {31'd0, s_bvalid}, 32'd0);
        chk("readys_back", {30'd0, s_awready, s_wready}, 32'd3);
        chk("mem_w_pulses", wpulse - p0, exp_ok ? 32'd1 : 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        s_awaddr  = '0;
        s_awvalid = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        repeat (3) tick();
        chk("rst_readys", {30'd0, s_awready, s_wready}, 32'd0);
        chk("rst_b", {29'd0, s_bvalid, s_bresp}, 32'd0);
        chk("rst_mem", {22'd0, axi_mem_w, axi_mem_addr}, 32'd0);
        chk("rst_mem_data", axi_mem_data, 32'd0);
        reset = 1'b0;
        tick();
        chk("readys_after_rst", {30'd0, s_awready, s_wready}, 32'd3);

        axi_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 1'b1, 9'd4);
        axi_write(32'h8000_07FC, 32'h1234_5678, 4'hF, 3, 0, 1'b1, 9'd511);

        axi_write(32'h8000_0800, 32'hAAAA_0001, 4'hF, 0, 0, 1'b0, 9'd0);
        axi_write(32'h7FFF_FFFC, 32'hAAAA_0002, 4'hF, 1, 0, 1'b0, 9'd0);
        axi_write(32'h8000_0002, 32'hAAAA_0003, 4'hF, 0, 0, 1'b0, 9'd0);
        axi_write(32'h8000_0008, 32'hAAAA_0004, 4'h3, 0, 0, 1'b0, 9'd0);
        chk("mem_addr_retained", {23'd0, axi_mem_addr}, 32'd511);
        chk("mem_data_retained", axi_mem_data, 32'h1234_5678);

        axi_write(32'h8000_0000, 32'hCAFE_F00D, 4'hF, 0, 5, 1'b1, 9'd0);

`ifdef AXI_MEM_LOADER_WCOUNT_EN
        chk("wcount_ok_only", {22'd0, wcount}, 32'd3);
`endif

        // Reset lands the cycle after the AW handshake, before W shows up.
        s_awaddr  = 32'h8000_0040;
        s_awvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        chk("aw_captured", {31'd0, s_awready}, 32'd0);
        reset = 1'b1;
        tick();
        chk("midrst_readys", {30'd0, s_awready, s_wready}, 32'd0);
        chk("midrst_b", {29'd0, s_bvalid, s_bresp}, 32'd0);
        chk("midrst_mem", {22'd0, axi_mem_w, axi_mem_addr}, 32'd0);
        chk("midrst_mem_data", axi_mem_data, 32'd0);
`ifdef AXI_MEM_LOADER_WCOUNT_EN
        chk("wcount_rst", {22'd0, wcount}, 32'd0);
`endif
        reset = 1'b0;
        tick();
        chk("readys_after_midrst", {30'd0, s_awready, s_wready}, 32'd3);
        repeat (3) begin
            tick();
            chk("no_stale_b", {31'd0, s_bvalid}, 32'd0);
        end

        axi_write(32'h8000_0020, 32'hA5A5_A5A5, 4'hF, 2, 0, 1'b1, 9'd8);
`ifdef AXI_MEM_LOADER_WCOUNT_EN
        chk("wcount_after_rst", {22'd0, wcount}, 32'd1);
`endif

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

endmodule
